// File: rtl/mux8_scan_ctrl.sv
// mux8_scan_ctrl
// Scan sequencer for an 8:1 single-bit mux. It steps the select lines through
// channels 0..7 and holds each channel for SETTLE+1 cycles. In the last cycle
// of each hold it samples Y. After channel 7 it publishes the 8 samples as one
// snapshot word. A scan is started by a start pulse while idle. While cont is
// high, scans repeat back-to-back.
//
// Ports
//   clk    : clock, rising edge
//   rst    : asynchronous reset, active high
//   start  : begin a scan (only honoured in IDLE, or at the end of a scan)
//   cont   : continuous mode; sampled at the end of each scan
//   Y      : mux output, combinational from S2..S0
//   S2..S0 : registered mux select, {S2,S1,S0} == current channel
//   busy   : scan in progress
//   done   : one-cycle pulse, high in the cycle that data is updated
//   data   : snapshot, data[k] = Y sampled with select k
module mux8_scan_ctrl #(
    parameter int unsigned SETTLE = 2   // legal 1..15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       cont,
    input  logic       Y,
    output logic       S0,
    output logic       S1,
    output logic       S2,
    output logic       busy,
    output logic       done,
    output logic [7:0] data
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;

    localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

    logic [1:0] state;
    logic [2:0] ch;
    logic [3:0] cnt;
    logic [7:0] shadow;
    logic [7:0] shadow_nxt;

    // Shadow with the current channel's sample merged in. On channel 7 this
    // is the completed snapshot, so data can load it in the same edge.
    always_comb begin
        shadow_nxt     = shadow;
        shadow_nxt[ch] = Y;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            ch     <= 3'd0;
            cnt    <= 4'd0;
            shadow <= 8'h00;
            data   <= 8'h00;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    ch <= 3'd0;
                    if (start) begin
                        cnt   <= 4'd0;
                        state <= ST_SETTLE;
                    end
                end
                // SETTLE cycles here plus the single SAMPLE cycle give a
                // channel period of SETTLE+1 with a stable select.
                ST_SETTLE: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == CNT_LAST)
                        state <= ST_SAMPLE;
                end
                ST_SAMPLE: begin
                    shadow <= shadow_nxt;
                    cnt    <= 4'd0;
                    if (ch != 3'd7) begin
                        ch    <= ch + 3'd1;
                        state <= ST_SETTLE;
                    end else begin
                        data  <= shadow_nxt;
                        done  <= 1'b1;
                        ch    <= 3'd0;
                        state <= (cont || start) ? ST_SETTLE : ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign {S2, S1, S0} = ch;
    assign busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_mux8_scan_ctrl.sv
// Bench for mux8_scan_ctrl. It drives one instance with SETTLE=2 and one with
// SETTLE=1. Each instance feeds a behavioural 8:1 mux. The stimulus pushes the
// expected snapshot and done cycle into a queue. A negedge monitor pops the
// queue on every done and compares.
module tb_mux8_scan_ctrl;

    typedef struct {
        logic [7:0] d;
        int         c;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start0 = 1'b0, start1 = 1'b0;
    logic       cont0 = 1'b0;
    logic [7:0] mux0 = 8'h00, mux1 = 8'h00;
    logic       y0, y1;
    logic       s0_0, s1_0, s2_0, busy0, done0;
    logic       s0_1, s1_1, s2_1, busy1, done1;
    logic [7:0] data0, data1;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    exp_t q0[$];
    exp_t q1[$];

    assign y0 = mux0[{s2_0, s1_0, s0_0}];
    assign y1 = mux1[{s2_1, s1_1, s0_1}];

    mux8_scan_ctrl #(.SETTLE(2)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .cont(cont0), .Y(y0),
        .S0(s0_0), .S1(s1_0), .S2(s2_0), .busy(busy0), .done(done0), .data(data0)
    );

    mux8_scan_ctrl #(.SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .cont(1'b0), .Y(y1),
        .S0(s0_1), .S1(s1_1), .S2(s2_1), .busy(busy1), .done(done1), .data(data1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bad(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got event expected none (cyc %0d)", name, cyc);
    endtask

    // Monitor: every done must match the head of its scoreboard queue.
    always @(negedge clk) begin
        exp_t e;
        if (done0 === 1'b1) begin
            if (q0.size() == 0) bad("done0_unexpected");
            else begin
                e = q0.pop_front();
                chk("data0", int'(data0), int'(e.d));
                chk("done0_cycle", cyc, e.c);
            end
        end
        if (done1 === 1'b1) begin
            if (q1.size() == 0) bad("done1_unexpected");
            else begin
                e = q1.pop_front();
                chk("data1", int'(data1), int'(e.d));
                chk("done1_cycle", cyc, e.c);
            end
        end
    end

    // Pulse start for one cycle. This returns at the negedge just after edge
    // E0 (k=0). When push is set, the expected result is queued.
    task automatic pulse(input bit which, input bit push, input logic [7:0] d,
                         input int len, output int e0);
        exp_t e;
        @(negedge clk);
        if (which) start1 = 1'b1; else start0 = 1'b1;
        e0  = cyc + 1;
        e.d = d;
        e.c = e0 + len;
        if (push) begin
            if (which) q1.push_back(e); else q0.push_back(e);
        end
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int e0;
        int t;

        // Reset state
        #2;
        chk("rst_sel", int'({s2_0, s1_0, s0_0}), 0);
        chk("rst_busy", int'(busy0), 0);
        chk("rst_done", int'(done0), 0);
        chk("rst_data", int'(data0), 0);
        idle(2);
        rst = 1'b0;

        // Static pattern with SETTLE=2: select stability and busy window
        mux0 = 8'hA6;
        pulse(1'b0, 1'b1, 8'hA6, 24, e0);
        for (int k = 0; k <= 24; k++) begin
            chk("sel_hold", int'({s2_0, s1_0, s0_0}), (k / 3) % 8);
            chk("busy_scan", int'(busy0), (k < 24) ? 1 : 0);
            if (k < 24) @(negedge clk);
        end
        chk("data_a6", int'(data0), 8'hA6);
        idle(3);

        // A start issued while busy is ignored: one done, no second scan
        mux0 = 8'h5A;
        pulse(1'b0, 1'b1, 8'h5A, 24, e0);
        idle(9);
        start0 = 1'b1;
        idle(1);
        start0 = 1'b0;
        idle(15);
        chk("ign_busy_done", int'(busy0), 0);
        idle(30);
        chk("ign_busy_after", int'(busy0), 0);
        chk("ign_data_hold", int'(data0), 8'h5A);

        // Continuous mode: back-to-back scans, then one final scan after cont drops
        cont0 = 1'b1;
        mux0  = 8'h3C;
        pulse(1'b0, 1'b1, 8'h3C, 24, e0);
        begin
            exp_t e;
            e.d = 8'hC3;
            e.c = e0 + 48;
            q0.push_back(e);
        end
        for (int k = 0; k < 48; k++) begin
            if (k == 24) mux0 = 8'hC3;
            if (k == 30) cont0 = 1'b0;
            chk("cont_busy", int'(busy0), 1);
            @(negedge clk);
        end
        chk("cont_busy_end", int'(busy0), 0);
        chk("cont_data", int'(data0), 8'hC3);
        idle(30);

        // Reset mid-scan after a scan has left A6 in data
        mux0 = 8'hA6;
        pulse(1'b0, 1'b1, 8'hA6, 24, e0);
        idle(26);
        chk("pre_rst_data", int'(data0), 8'hA6);
        pulse(1'b0, 1'b0, 8'h00, 24, e0);
        idle(13);
        chk("pre_rst_sel", int'({s2_0, s1_0, s0_0}), 4);
        rst = 1'b1;
        #1;
        chk("mid_rst_sel", int'({s2_0, s1_0, s0_0}), 0);
        chk("mid_rst_busy", int'(busy0), 0);
        chk("mid_rst_data", int'(data0), 0);
        chk("mid_rst_done", int'(done0), 0);
        @(negedge clk);
        rst = 1'b0;
        idle(30);
        pulse(1'b0, 1'b1, 8'hA6, 24, e0);
        idle(26);

        // SETTLE=1 boundary: 2-cycle channel period, done 16 edges after start
        mux1 = 8'h5B;
        pulse(1'b1, 1'b1, 8'h5B, 16, e0);
        for (int k = 0; k <= 16; k++) begin
            chk("s1_sel_hold", int'({s2_1, s1_1, s0_1}), (k / 2) % 8);
            chk("s1_busy", int'(busy1), (k < 16) ? 1 : 0);
            if (k < 16) @(negedge clk);
        end
        idle(5);

        // Every queued expectation must have been consumed
        t = 0;
        while ((q0.size() != 0 || q1.size() != 0) && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("scoreboard_drain", q0.size() + q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
